// File: rtl/mult_pkg.sv
// Shared definitions for the 12-bit unsigned shift-add multiplier.
// Contents: sequencer state encoding, default operand width and the
// default load-wait limit used by the optional LOAD_TIMEOUT_EN feature.
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_LOAD = 3'd2,
    S_MULT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int WIDTH_DEF        = 12;
  localparam int LOAD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/shift_add_core.sv
// Shift-add datapath: multiplicand register, 2*WIDTH accumulator with a
// carry bit and the iteration counter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load_i      - capture mcand_i and mplier_i, clear high half, carry, counter
//   step_i      - perform one conditional-add / shift-right iteration
//   mcand_i     - multiplicand (x operand)
//   mplier_i    - multiplier (y operand), loaded into the accumulator low half
//   acc_o       - accumulator; holds the product after WIDTH steps
//   last_o      - high while the counter sits on the final iteration
module shift_add_core
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic                 last_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               c_q, c_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     add_w;

  assign last_o = (cnt_q == CNT_LAST);
  assign acc_o  = acc_q;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    // Conditional add keeps the carry out so 4095*4095 style sums survive
    // the shift; with acc[0]=0 the high half passes through unchanged.
    if (acc_q[0]) add_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    else          add_w = {c_q, acc_q[2*WIDTH-1:WIDTH]};
    if (load_i) begin
      mcand_d = mcand_i;
      acc_d   = {{WIDTH{1'b0}}, mplier_i};
      c_d     = 1'b0;
      cnt_d   = '0;
    end else if (step_i) begin
      // {c,acc} >> 1 with the carry entering the MSB; carry becomes 0
      acc_d = {add_w, acc_q[WIDTH-1:1]};
      c_d   = 1'b0;
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Top-level controller for the unsigned WIDTH x WIDTH multiplier.
// Arms the x/y serial loaders, waits for both full flags, runs WIDTH
// shift-add iterations in shift_add_core and presents the product with a
// one-cycle done pulse.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start                 - multiply request, sampled only in IDLE
//   fx, fy                - loader full flags
//   x_parallel/y_parallel - operands from the loaders
//   sx, sy                - loader start (0 in ARM so loaders see a rising edge)
//   busy                  - high in every state except IDLE
//   done                  - one-cycle pulse when product becomes valid
//   product               - result, held until the next done
//   error                 - load timeout flag (only with LOAD_TIMEOUT_EN)
// Optional feature macro: LOAD_TIMEOUT_EN (bounded wait in LOAD).
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 fx,
  input  logic                 fy,
  input  logic [WIDTH-1:0]     x_parallel,
  input  logic [WIDTH-1:0]     y_parallel,
  output logic                 sx,
  output logic                 sy,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef LOAD_TIMEOUT_EN
  ,
  output logic                 error
`endif
);

  state_e             state_q;
  logic               sx_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] core_acc;
  logic               core_last;
  logic               core_load;
  logic               core_step;

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOAD_TIMEOUT - 1);
  logic          error_q;
  logic [TW-1:0] tmo_q;
  assign error = error_q;
`endif

  assign sx      = sx_q;
  assign sy      = sx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  assign core_load = (state_q == S_LOAD) && fx && fy;
  assign core_step = (state_q == S_MULT);

  shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (core_load),
    .step_i   (core_step),
    .mcand_i  (x_parallel),
    .mplier_i (y_parallel),
    .acc_o    (core_acc),
    .last_o   (core_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sx_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef LOAD_TIMEOUT_EN
      error_q   <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
            error_q <= 1'b0;
`endif
          end
        end
        S_ARM: begin
          state_q <= S_LOAD;
          sx_q    <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        S_LOAD: begin
          // Both flags must be high in the same cycle; a lone flag waits.
          if (fx && fy) begin
            state_q <= S_MULT;
            sx_q    <= 1'b0;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= S_IDLE;
            sx_q    <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        S_MULT: begin
          if (core_last) state_q <= S_DONE;
        end
        S_DONE: begin
          // Accumulator is final only after the last step has landed.
          product_q <= core_acc;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          sx_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
